// File: rtl/ucode_issue_ctrl_pkg.sv
// Shared ISA constants for the MUL microcode path: opcodes, field positions, bubble word,
// and the issue-controller state encoding. Imported by the sequencer, decoder and issue control.
package ucode_issue_ctrl_pkg;

   localparam int INSTR_W = 32;

   localparam logic [6:0] OP_MULI  = 7'b0010011;
   localparam logic [6:0] OP_MULR  = 7'b0110011;
   localparam logic [6:0] OP_MULSI = 7'b0011011;
   localparam logic [6:0] OP_MULSR = 7'b0111011;
   localparam logic [6:0] OP_MOV   = 7'b0000001;
   localparam logic [6:0] OP_ADD   = 7'b0000011;
   localparam logic [6:0] OP_ADDS  = 7'b0001011;
   localparam logic [6:0] OP_SUB   = 7'b0100011;
   localparam logic [6:0] OP_SUBI  = 7'b0000111;
   localparam logic [6:0] OP_NOT   = 7'b0101011;

   localparam int OPC_HI  = 31;
   localparam int OPC_LO  = 25;
   localparam int DEST_HI = 24;
   localparam int DEST_LO = 21;
   localparam int SRC_HI  = 20;
   localparam int SRC_LO  = 17;
   localparam int SEC_HI  = 16;
   localparam int SEC_LO  = 13;
   localparam int IMM_HI  = 15;
   localparam int IMM_LO  = 0;

   localparam logic [INSTR_W-1:0] NOP_WORD_DEF = {5'b11001, 27'b0};

   typedef enum logic [1:0] {
      MUL_I  = 2'd0,
      MUL_R  = 2'd1,
      MUL_SI = 2'd2,
      MUL_SR = 2'd3
   } mul_type_e;

   typedef enum logic [1:0] {
      ST_PASS   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_INJECT = 2'd2,
      ST_RESUME = 2'd3
   } issue_state_e;

   function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] w);
      return w[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/ucode_issue_ctrl_mul_detect.sv
// Combinational MUL opcode classifier: flags any of the four MUL forms and encodes which one.
// Zero latency; no flow control.
module ucode_issue_ctrl_mul_detect
   import ucode_issue_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic       o_is_mul,
   output mul_type_e  o_mul_type
);

   always_comb begin
      o_is_mul   = 1'b1;
      o_mul_type = MUL_I;
      unique case (i_opcode)
         OP_MULI:  o_mul_type = MUL_I;
         OP_MULR:  o_mul_type = MUL_R;
         OP_MULSI: o_mul_type = MUL_SI;
         OP_MULSR: o_mul_type = MUL_SR;
         default:  o_is_mul   = 1'b0;
      endcase
   end

endmodule

// File: rtl/ucode_issue_ctrl.sv
// Fetch-side issue control for the MUL microcode sequencer: traps MUL words, stalls PC, launches the
// sequencer, forwards injected words to ID and restores flags; ID word has 1-cycle latency.
module ucode_issue_ctrl
   import ucode_issue_ctrl_pkg::*;
#(
   parameter int                   TIMEOUT_W = 17,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 17'd70000,
   parameter logic [31:0]          NOP_WORD  = NOP_WORD_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_instr,
   input  logic        if_valid,
   input  logic [31:0] uc_instr,
   input  logic        uc_mux_ctrl,
   input  logic        uc_mul_release,
   input  logic [3:0]  uc_flags,
   output logic        pc_stall,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        start_mul,
   output logic [1:0]  mul_type,
   output logic [3:0]  dest_reg,
   output logic [3:0]  source_reg,
   output logic [3:0]  second_reg,
   output logic [15:0] immediate,
   output logic        flags_wr_en,
   output logic [3:0]  flags_wr,
   output logic        mul_error
);

   issue_state_e         r_state, w_next;
   logic                 w_is_mul;
   mul_type_e            w_mul_type;
   logic                 w_take_mul;
   logic                 w_wd_expired;
   logic [TIMEOUT_W-1:0] r_wd;
   logic                 r_abort;
   logic                 r_err;
   logic [31:0]          r_id_instr;
   logic                 r_id_valid;
   logic [1:0]           r_mul_type;
   logic [3:0]           r_dest, r_src, r_sec, r_flags;
   logic [15:0]          r_imm;

   ucode_issue_ctrl_mul_detect u_mul_detect (
      .i_opcode   (opcode_of(if_instr)),
      .o_is_mul   (w_is_mul),
      .o_mul_type (w_mul_type)
   );

   assign w_take_mul   = (r_state == ST_PASS) && if_valid && w_is_mul;
   assign w_wd_expired = (r_wd == (TIMEOUT - TIMEOUT_W'(1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_PASS;
      else      r_state <= w_next;
   end

   // Release is tested before the watchdog so a release on the last allowed cycle still restores flags.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_PASS:   if (w_take_mul) w_next = ST_LAUNCH;
         ST_LAUNCH: w_next = ST_INJECT;
         ST_INJECT: if (uc_mul_release || w_wd_expired) w_next = ST_RESUME;
         ST_RESUME: w_next = ST_PASS;
         default:   w_next = ST_PASS;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_id_instr <= NOP_WORD;
         r_id_valid <= 1'b0;
         r_mul_type <= 2'd0;
         r_dest     <= 4'd0;
         r_src      <= 4'd0;
         r_sec      <= 4'd0;
         r_imm      <= 16'd0;
         r_flags    <= 4'd0;
         r_wd       <= '0;
         r_abort    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_id_instr <= NOP_WORD;
         r_id_valid <= 1'b0;
         unique case (r_state)
            ST_PASS: begin
               if (if_valid && !w_is_mul) begin
                  r_id_instr <= if_instr;
                  r_id_valid <= 1'b1;
               end
               if (w_take_mul) begin
                  r_mul_type <= w_mul_type;
                  r_dest     <= if_instr[DEST_HI:DEST_LO];
                  r_src      <= if_instr[SRC_HI:SRC_LO];
                  r_sec      <= if_instr[SEC_HI:SEC_LO];
                  r_imm      <= if_instr[IMM_HI:IMM_LO];
               end
            end
            ST_LAUNCH: begin
               r_wd    <= '0;
               r_abort <= 1'b0;
            end
            ST_INJECT: begin
               if (uc_mux_ctrl) begin
                  r_id_instr <= uc_instr;
                  r_id_valid <= 1'b1;
               end
               r_wd <= r_wd + 1'b1;
               if (uc_mul_release) begin
                  r_flags <= uc_flags;
               end else if (w_wd_expired) begin
                  r_abort <= 1'b1;
                  r_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pc_stall    = w_take_mul || (r_state == ST_LAUNCH) || (r_state == ST_INJECT);
   assign start_mul   = (r_state == ST_LAUNCH);
   assign flags_wr_en = (r_state == ST_RESUME) && !r_abort;
   assign flags_wr    = r_flags;
   assign id_instr    = r_id_instr;
   assign id_valid    = r_id_valid;
   assign mul_type    = r_mul_type;
   assign dest_reg    = r_dest;
   assign source_reg  = r_src;
   assign second_reg  = r_sec;
   assign immediate   = r_imm;
   assign mul_error   = r_err;

endmodule

// File: tb/tb_ucode_issue_ctrl.sv
// Self-checking bench for ucode_issue_ctrl: random pass-through traffic and scripted MUL sequences
// checked against a phase-level model of the issue protocol.
module tb_ucode_issue_ctrl;

   localparam logic [31:0] NOP = {5'b11001, 27'b0};
   localparam int          TO  = 16;

   logic        clk, rst;
   logic [31:0] if_instr, uc_instr;
   logic        if_valid, uc_mux_ctrl, uc_mul_release;
   logic [3:0]  uc_flags;
   logic        pc_stall, id_valid, start_mul, flags_wr_en, mul_error;
   logic [31:0] id_instr;
   logic [1:0]  mul_type;
   logic [3:0]  dest_reg, source_reg, second_reg, flags_wr;
   logic [15:0] immediate;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_err  = 1'b0;
   int n_starts = 0;

   ucode_issue_ctrl #(.TIMEOUT_W(17), .TIMEOUT(17'd16), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid), .uc_instr(uc_instr),
      .uc_mux_ctrl(uc_mux_ctrl), .uc_mul_release(uc_mul_release), .uc_flags(uc_flags),
      .pc_stall(pc_stall), .id_instr(id_instr), .id_valid(id_valid), .start_mul(start_mul),
      .mul_type(mul_type), .dest_reg(dest_reg), .source_reg(source_reg), .second_reg(second_reg),
      .immediate(immediate), .flags_wr_en(flags_wr_en), .flags_wr(flags_wr), .mul_error(mul_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (start_mul === 1'b1) n_starts++;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running, required to finish");
      $fatal(1, "timeout");
   end

   function automatic int mul_code(input logic [31:0] w);
      case (w >> 25)
         32'h13:  return 0;
         32'h33:  return 1;
         32'h1B:  return 2;
         32'h3B:  return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] rand_plain();
      logic [31:0] w;
      w = $urandom;
      if (mul_code(w) >= 0) w = w ^ 32'h0200_0000;
      return w;
   endfunction

   function automatic logic [31:0] mk_mul(input int code, input int d, input int s, input int low17);
      int op;
      op = (code == 0) ? 32'h13 : (code == 1) ? 32'h33 : (code == 2) ? 32'h1B : 32'h3B;
      return 32'((op << 25) | ((d & 15) << 21) | ((s & 15) << 17) | (low17 & 32'h1FFFF));
   endfunction

   task automatic pass_cycle(input logic [31:0] w, input logic v);
      if_instr = w; if_valid = v;
      uc_mux_ctrl = 1'($urandom); uc_instr = $urandom;
      uc_mul_release = 1'($urandom); uc_flags = 4'($urandom);
      #1;
      n_checks++; if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL pass_pc_stall: got %b want 0", pc_stall); end
      n_checks++; if (flags_wr_en !== 1'b0) begin n_fail++; $display("FAIL pass_flags_wr_en: got %b want 0", flags_wr_en); end
      @(posedge clk); #1;
      n_checks++; if (id_valid !== v) begin n_fail++; $display("FAIL pass_id_valid: got %b want %b", id_valid, v); end
      n_checks++; if (id_instr !== (v ? w : NOP)) begin n_fail++; $display("FAIL pass_id_instr: got %h want %h", id_instr, v ? w : NOP); end
      n_checks++; if (start_mul !== 1'b0) begin n_fail++; $display("FAIL pass_start_mul: got %b want 0", start_mul); end
      n_checks++; if (mul_error !== exp_err) begin n_fail++; $display("FAIL pass_mul_error: got %b want %b", mul_error, exp_err); end
   endtask

   // One full MUL: trap, launch, n inject cycles (release on the last if rel), resume.
   task automatic run_mul(input logic [31:0] w, input int n, input bit rel, input logic [3:0] flg, input bit gaps);
      logic [3:0]  ed, es, et;
      logic [15:0] ei;
      logic [1:0]  em;
      logic        mx;
      logic [31:0] u;
      ed = 4'((w >> 21) & 15); es = 4'((w >> 17) & 15); et = 4'((w >> 13) & 15);
      ei = 16'(w & 32'hFFFF);  em = 2'(mul_code(w));
      if_instr = w; if_valid = 1'b1; uc_mux_ctrl = 1'b1; uc_instr = $urandom; uc_mul_release = 1'b1;
      #1;
      n_checks++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL trap_pc_stall: got %b want 1", pc_stall); end
      @(posedge clk); #1;
      n_checks++; if (start_mul !== 1'b1) begin n_fail++; $display("FAIL launch_start_mul: got %b want 1", start_mul); end
      n_checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin n_fail++; $display("FAIL trap_id: got %b/%h want 0/%h", id_valid, id_instr, NOP); end
      n_checks++; if ({mul_type, dest_reg, source_reg, second_reg, immediate} !== {em, ed, es, et, ei})
         begin n_fail++; $display("FAIL launch_operands: got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h",
            mul_type, dest_reg, source_reg, second_reg, immediate, em, ed, es, et, ei); end
      if_instr = rand_plain(); uc_mux_ctrl = 1'b1; uc_mul_release = 1'b1; uc_flags = 4'($urandom);
      #1;
      n_checks++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL launch_pc_stall: got %b want 1", pc_stall); end
      @(posedge clk); #1;
      n_checks++; if (start_mul !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL launch_exit: start %b id_valid %b want 0/0", start_mul, id_valid); end
      for (int i = 0; i < n; i++) begin
         mx = gaps ? 1'($urandom) : 1'b1;
         u  = $urandom;
         uc_mux_ctrl = mx; uc_instr = u;
         uc_mul_release = rel && (i == n - 1);
         uc_flags = (rel && (i == n - 1)) ? flg : 4'($urandom);
         #1;
         n_checks++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL inject_pc_stall[%0d]: got %b want 1", i, pc_stall); end
         @(posedge clk); #1;
         n_checks++; if (id_valid !== mx || id_instr !== (mx ? u : NOP))
            begin n_fail++; $display("FAIL inject_id[%0d]: got %b/%h want %b/%h", i, id_valid, id_instr, mx, mx ? u : NOP); end
         n_checks++; if (second_reg !== et || start_mul !== 1'b0)
            begin n_fail++; $display("FAIL inject_hold[%0d]: second %h start %b want %h/0", i, second_reg, start_mul, et); end
      end
      if (!rel) exp_err = 1'b1;
      uc_mux_ctrl = 1'b0; uc_mul_release = 1'b0; if_instr = rand_plain(); if_valid = 1'b1;
      #1;
      n_checks++; if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL resume_pc_stall: got %b want 0", pc_stall); end
      n_checks++; if (flags_wr_en !== rel) begin n_fail++; $display("FAIL resume_flags_wr_en: got %b want %b", flags_wr_en, rel); end
      if (rel) begin
         n_checks++; if (flags_wr !== flg) begin n_fail++; $display("FAIL resume_flags_wr: got %b want %b", flags_wr, flg); end
      end
      n_checks++; if (mul_error !== exp_err) begin n_fail++; $display("FAIL resume_mul_error: got %b want %b", mul_error, exp_err); end
      @(posedge clk); #1;
      n_checks++; if (id_valid !== 1'b0 || flags_wr_en !== 1'b0)
         begin n_fail++; $display("FAIL resume_exit: id_valid %b flags_wr_en %b want 0/0", id_valid, flags_wr_en); end
   endtask

   task automatic test_reset();
      rst = 1'b0; if_instr = '0; if_valid = 1'b0; uc_instr = '0;
      uc_mux_ctrl = 1'b0; uc_mul_release = 1'b0; uc_flags = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (id_instr !== NOP || id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %h/%b want %h/0", id_instr, id_valid, NOP); end
      n_checks++; if (pc_stall !== 1'b0 || start_mul !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: stall %b start %b want 0/0", pc_stall, start_mul); end
      n_checks++; if ({flags_wr_en, flags_wr, mul_error} !== 6'd0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b want 0", flags_wr_en, flags_wr, mul_error); end
      n_checks++; if ({mul_type, dest_reg, source_reg, second_reg, immediate} !== 30'd0)
         begin n_fail++; $display("FAIL reset_operands: got %h want 0", {mul_type, dest_reg, source_reg, second_reg, immediate}); end
      rst = 1'b1;
   endtask

   task automatic test_passthrough();
      for (int i = 0; i < 24; i++) pass_cycle(rand_plain(), (i % 5 == 3) ? 1'b0 : 1'($urandom | 32'((i & 1) == 0)));
   endtask

   task automatic test_muli();
      run_mul(mk_mul(0, 1, 0, 3), 4, 1'b1, 4'b1010, 1'b0);
      pass_cycle(rand_plain(), 1'b1);
   endtask

   task automatic test_mulr_gaps();
      run_mul(mk_mul(1, 2, 3, 4 << 13), 10, 1'b1, 4'($urandom), 1'b1);
      pass_cycle(rand_plain(), 1'b1);
   endtask

   task automatic test_back_to_back();
      int s0;
      s0 = n_starts;
      run_mul(mk_mul(2, 5, 6, int'($urandom_range(0, 32'h1FFFF))), 3, 1'b1, 4'b0110, 1'b1);
      run_mul(mk_mul(3, 7, 8, int'($urandom_range(0, 32'h1FFFF))), 5, 1'b1, 4'b1001, 1'b0);
      pass_cycle(rand_plain(), 1'b1);
      n_checks++; if (n_starts - s0 !== 2) begin n_fail++; $display("FAIL b2b_start_count: got %0d want 2", n_starts - s0); end
   endtask

   task automatic test_watchdog();
      run_mul(mk_mul(1, 9, 10, int'($urandom_range(0, 32'h1FFFF))), TO, 1'b0, 4'b0000, 1'b1);
      pass_cycle(rand_plain(), 1'b1);
      run_mul(mk_mul(0, 11, 12, 77), TO, 1'b1, 4'b0101, 1'b0);
      pass_cycle(rand_plain(), 1'b1);
   endtask

   task automatic test_reset_mid();
      if_instr = mk_mul(2, 3, 4, 5); if_valid = 1'b1; uc_mux_ctrl = 1'b0; uc_mul_release = 1'b0;
      @(posedge clk); #1;
      if_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      uc_mux_ctrl = 1'b1; uc_instr = $urandom;
      rst = 1'b0; exp_err = 1'b0;
      #1;
      n_checks++; if (pc_stall !== 1'b0 || id_valid !== 1'b0 || start_mul !== 1'b0 || mul_error !== 1'b0)
         begin n_fail++; $display("FAIL midreset_outputs: stall %b id_valid %b start %b err %b want 0000", pc_stall, id_valid, start_mul, mul_error); end
      n_checks++; if (id_instr !== NOP || dest_reg !== 4'd0) begin n_fail++; $display("FAIL midreset_regs: got %h/%h want %h/0", id_instr, dest_reg, NOP); end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) pass_cycle(rand_plain(), 1'b1);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_muli();
      test_mulr_gaps();
      test_back_to_back();
      test_watchdog();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
